// File: rtl/wb_load_unit.sv
// wb_load_unit: MEM-stage load/store unit with one outstanding load, alignment check and response timeout
module wb_load_unit #(
  parameter int DATA_W     = 32,
  parameter int REG_ADDR_W = 5,
  parameter int MAX_WAIT   = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  input  logic                  mem_read_flag,
  input  logic                  mem_write_flag,
  input  logic                  mem_sign_flag,
  input  logic [1:0]            mem_size,
  input  logic [DATA_W-1:0]     result_in,
  input  logic                  reg_write_en_in,
  input  logic [REG_ADDR_W-1:0] reg_write_addr_in,
  input  logic                  mem_resp_valid,
  input  logic [DATA_W-1:0]     ram_read_data,
  output logic                  out_valid,
  output logic [DATA_W-1:0]     result_out,
  output logic                  reg_write_en_out,
  output logic [REG_ADDR_W-1:0] reg_write_addr_out,
  output logic                  stall_req,
  output logic                  addr_error,
  output logic                  bus_error
);
  localparam int OFF_W = $clog2(DATA_W / 8);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] WAIT = 1'b1;

  logic [0:0]            state_q, state_d;
  logic [7:0]            cnt_q, cnt_d;
  logic [1:0]            size_q, size_d;
  logic                  sign_q, sign_d, wen_q, wen_d;
  logic [OFF_W-1:0]      off_q, off_d;
  logic [REG_ADDR_W-1:0] dst_q, dst_d;
  logic                  valid_q, valid_d, aerr_q, aerr_d, berr_q, berr_d, rwe_q, rwe_d;
  logic [DATA_W-1:0]     res_q, res_d;
  logic [REG_ADDR_W-1:0] rwa_q, rwa_d;
  logic [OFF_W-1:0]      off;
  logic                  misal, dst_nz, sbit;
  logic [DATA_W-1:0]     sh, mask, lane;

  assign off    = result_in[OFF_W-1:0];
  assign misal  = mem_size == 2'd0 ? 1'b0 :
                  mem_size == 2'd1 ? off[0] :
                  mem_size == 2'd2 ? |off[1:0] : (DATA_W == 32) || (|off);
  assign dst_nz = |reg_write_addr_in;

  // lane extraction: shift the addressed byte down to bit 0, then mask and extend by size
  assign sh   = ram_read_data >> {off_q, 3'b000};
  assign mask = size_q == 2'd0 ? DATA_W'(8'hFF) :
                size_q == 2'd1 ? DATA_W'(16'hFFFF) :
                size_q == 2'd2 ? DATA_W'(32'hFFFF_FFFF) : '1;
  assign sbit = size_q == 2'd0 ? sh[7] :
                size_q == 2'd1 ? sh[15] :
                size_q == 2'd2 ? sh[31] : sh[DATA_W-1];
  assign lane = (sh & mask) | (sign_q && sbit ? ~mask : '0);

  assign out_valid          = valid_q;
  assign result_out         = res_q;
  assign reg_write_en_out   = rwe_q;
  assign reg_write_addr_out = rwa_q;
  assign addr_error         = aerr_q;
  assign bus_error          = berr_q;
  assign stall_req          = state_q == WAIT;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    size_d  = size_q;
    sign_d  = sign_q;
    off_d   = off_q;
    dst_d   = dst_q;
    wen_d   = wen_q;
    valid_d = 1'b0;
    aerr_d  = 1'b0;
    berr_d  = 1'b0;
    res_d   = res_q;
    rwe_d   = rwe_q;
    rwa_d   = rwa_q;
    if (state_q == IDLE && in_valid) begin
      rwa_d = reg_write_addr_in;
      if ((mem_read_flag || mem_write_flag) && misal) begin
        valid_d = 1'b1;
        aerr_d  = 1'b1;
        res_d   = '0;
        rwe_d   = 1'b0;
      end else if (mem_read_flag) begin
        state_d = WAIT;
        cnt_d   = '0;
        size_d  = mem_size;
        sign_d  = mem_sign_flag;
        off_d   = off;
        dst_d   = reg_write_addr_in;
        wen_d   = reg_write_en_in && dst_nz;
        rwa_d   = rwa_q;
      end else if (mem_write_flag) begin
        valid_d = 1'b1;
        res_d   = '0;
        rwe_d   = 1'b0;
      end else begin
        valid_d = 1'b1;
        res_d   = result_in;
        rwe_d   = reg_write_en_in && dst_nz;
      end
    end else if (state_q == WAIT) begin
      if (mem_resp_valid) begin
        state_d = IDLE;
        valid_d = 1'b1;
        res_d   = lane;
        rwe_d   = wen_q;
        rwa_d   = dst_q;
      end else if (cnt_q == 8'(MAX_WAIT - 1)) begin
        state_d = IDLE;
        valid_d = 1'b1;
        berr_d  = 1'b1;
        res_d   = '0;
        rwe_d   = 1'b0;
        rwa_d   = dst_q;
      end else begin
        cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      size_q  <= '0;
      sign_q  <= 1'b0;
      off_q   <= '0;
      dst_q   <= '0;
      wen_q   <= 1'b0;
      valid_q <= 1'b0;
      aerr_q  <= 1'b0;
      berr_q  <= 1'b0;
      res_q   <= '0;
      rwe_q   <= 1'b0;
      rwa_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      size_q  <= size_d;
      sign_q  <= sign_d;
      off_q   <= off_d;
      dst_q   <= dst_d;
      wen_q   <= wen_d;
      valid_q <= valid_d;
      aerr_q  <= aerr_d;
      berr_q  <= berr_d;
      res_q   <= res_d;
      rwe_q   <= rwe_d;
      rwa_q   <= rwa_d;
    end
  end
endmodule

// File: tb/tb_wb_load_unit.sv
// tb_wb_load_unit: 32- and 64-bit units on shared stimulus, scoreboarded against an arithmetic model
module tb_wb_load_unit;
  localparam int MAXW = 4;

  typedef struct packed {
    logic [63:0] res;
    logic        we, ae, be, chkwa;
    logic [4:0]  wa;
  } exp_t;

  logic        clk, rst, in_valid, rd_f, wr_f, sg_f, we_in, resp;
  logic [1:0]  sz;
  logic [63:0] res_in, ram;
  logic [4:0]  wa_in;
  logic        ov32, we32, st32, ae32, be32, ov64, we64, st64, ae64, be64;
  logic [31:0] r32;
  logic [63:0] r64;
  logic [4:0]  wa32, wa64;

  exp_t q0[$], q1[$];
  int   sq0[$], sq1[$];
  int   errors = 0, checks = 0;
  int   run[2];
  logic [63:0] last_res[2];
  logic        last_we[2];
  bit   rst_prev = 0, done = 0;

  wb_load_unit #(.DATA_W(32), .REG_ADDR_W(5), .MAX_WAIT(MAXW)) u32 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read_flag(rd_f), .mem_write_flag(wr_f),
    .mem_sign_flag(sg_f), .mem_size(sz), .result_in(res_in[31:0]), .reg_write_en_in(we_in),
    .reg_write_addr_in(wa_in), .mem_resp_valid(resp), .ram_read_data(ram[31:0]),
    .out_valid(ov32), .result_out(r32), .reg_write_en_out(we32), .reg_write_addr_out(wa32),
    .stall_req(st32), .addr_error(ae32), .bus_error(be32));

  wb_load_unit #(.DATA_W(64), .REG_ADDR_W(5), .MAX_WAIT(MAXW)) u64 (
    .clk(clk), .rst(rst), .in_valid(in_valid), .mem_read_flag(rd_f), .mem_write_flag(wr_f),
    .mem_sign_flag(sg_f), .mem_size(sz), .result_in(res_in), .reg_write_en_in(we_in),
    .reg_write_addr_in(wa_in), .mem_resp_valid(resp), .ram_read_data(ram),
    .out_valid(ov64), .result_out(r64), .reg_write_en_out(we64), .reg_write_addr_out(wa64),
    .stall_req(st64), .addr_error(ae64), .bus_error(be64));

  initial clk = 0;
  always #5 clk = ~clk;

  // d = WAIT cycle in which the response arrives; d >= MAXW means it comes too late
  function automatic exp_t model(input int dw, input bit rd, wr, sg, input logic [1:0] size,
                                 input logic [63:0] res, input bit wen, input logic [4:0] wa,
                                 input logic [63:0] data, input int d, output bit acc);
    exp_t e;
    int nb, off;
    logic [63:0] v, m, dmask;
    nb = 1 << size;
    dmask = dw == 64 ? '1 : 64'hFFFF_FFFF;
    e = '0;
    acc = 0;
    e.wa = wa;
    if (rd || wr) begin
      if (nb > dw / 8 || int'(res[5:0]) % nb != 0) begin
        e.ae = 1;
        return e;
      end
      if (!rd) return e;
      acc = 1;
      if (d >= MAXW) begin
        e.be = 1;
        return e;
      end
      off = int'(res[2:0]) % (dw / 8);
      m = nb == 8 ? '1 : (64'd1 << (8 * nb)) - 64'd1;
      v = ((data & dmask) >> (8 * off)) & m;
      if (sg && v[8 * nb - 1]) v = v | ~m;
      e.res = v & dmask;
    end else e.res = res & dmask;
    e.we = wen && wa != 0;
    e.chkwa = 1;
    return e;
  endfunction

  task automatic expect_txn(input bit rd, wr, sg, input logic [1:0] size, input logic [63:0] res,
                            input bit wen, input logic [4:0] wa, input logic [63:0] data, input int d);
    bit acc;
    q0.push_back(model(32, rd, wr, sg, size, res, wen, wa, data, d, acc));
    if (acc) sq0.push_back(d < MAXW ? d + 1 : MAXW);
    q1.push_back(model(64, rd, wr, sg, size, res, wen, wa, data, d, acc));
    if (acc) sq1.push_back(d < MAXW ? d + 1 : MAXW);
  endtask

  task automatic present(input bit rd, wr, sg, input logic [1:0] size, input logic [63:0] res,
                         input bit wen, input logic [4:0] wa);
    in_valid = 1; rd_f = rd; wr_f = wr; sg_f = sg; sz = size; res_in = res; we_in = wen; wa_in = wa;
  endtask

  task automatic txn(input bit rd, wr, sg, input logic [1:0] size, input logic [63:0] res,
                     input bit wen, input logic [4:0] wa, input logic [63:0] data, input int d, input bit early);
    int lim;
    expect_txn(rd, wr, sg, size, res, wen, wa, data, d);
    @(posedge clk); #1;
    present(rd, wr, sg, size, res, wen, wa);
    resp = early;
    ram = {$urandom, $urandom};
    lim = d + 2 > 6 ? d + 2 : 6;
    for (int c = 1; c <= lim; c++) begin
      @(posedge clk); #1;
      in_valid = 0;
      resp = (c == d + 1);
      ram = data;
    end
  endtask

  function automatic void chk(input string n, input int k, input logic [63:0] a, input logic [63:0] x);
    checks++;
    if (a !== x) begin
      errors++;
      $display("FAIL %s dut%0d: got %h expected %h", n, k == 0 ? 32 : 64, a, x);
    end
  endfunction

  task automatic mon(input int k, input logic ov, input logic [63:0] r, input logic we,
                     input logic [4:0] wa, input logic ae, be, st);
    exp_t e;
    bit got;
    int xs;
    if (ov) begin
      got = k == 0 ? q0.size() != 0 : q1.size() != 0;
      chk("out_expected", k, ov, got);
      if (got) begin
        if (k == 0) e = q0.pop_front();
        else e = q1.pop_front();
        chk("result", k, r, e.res);
        chk("reg_we", k, we, e.we);
        chk("addr_error", k, ae, e.ae);
        chk("bus_error", k, be, e.be);
        if (e.chkwa) chk("reg_addr", k, wa, e.wa);
        last_res[k] = e.res;
        last_we[k] = e.we;
      end
    end else begin
      chk("hold_result", k, r, last_res[k]);
      chk("hold_we", k, we, last_we[k]);
      chk("idle_ae", k, ae, 0);
      chk("idle_be", k, be, 0);
    end
    if (st) begin
      run[k]++;
      if (run[k] > 20) begin
        chk("stall_stuck", k, run[k], 20);
        run[k] = 0;
      end
    end else if (run[k] != 0) begin
      got = k == 0 ? sq0.size() != 0 : sq1.size() != 0;
      chk("stall_expected", k, got, 1);
      if (got) begin
        if (k == 0) xs = sq0.pop_front();
        else xs = sq1.pop_front();
        chk("stall_cycles", k, run[k], xs);
      end
      run[k] = 0;
    end
  endtask

  always @(negedge clk) begin
    if (done) begin
      chk("exp_left", 0, q0.size(), 0);
      chk("exp_left", 1, q1.size(), 0);
      chk("stall_left", 0, sq0.size(), 0);
      chk("stall_left", 1, sq1.size(), 0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
    end
    if (rst_prev) begin
      last_res = '{64'd0, 64'd0};
      last_we = '{1'b0, 1'b0};
    end
    mon(0, ov32, {32'd0, r32}, we32, wa32, ae32, be32, st32);
    mon(1, ov64, r64, we64, wa64, ae64, be64, st64);
    rst_prev = rst;
  end

  logic [63:0] g_res, g_data;
  logic [1:0]  g_sz;
  logic [4:0]  g_wa;
  int          g_kind;

  initial begin
    run = '{0, 0};
    last_res = '{64'd0, 64'd0};
    last_we = '{1'b0, 1'b0};
    rst = 1; in_valid = 0; rd_f = 0; wr_f = 0; sg_f = 0; sz = 0; res_in = 0; we_in = 0; wa_in = 0;
    resp = 0; ram = 0;
    repeat (3) @(posedge clk);
    #1 rst = 0;
    txn(1, 0, 1, 0, 64'h1003, 1, 5'd7, 64'h80FF_0000, 1, 0);
    txn(1, 0, 0, 1, 64'h6, 1, 5'd8, 64'hBEEF_0000_0000_0000, 0, 0);
    txn(1, 0, 1, 2, 64'h2, 1, 5'd9, 64'h1234_5678_9ABC_DEF0, 0, 0);
    txn(1, 0, 0, 2, 64'h40, 1, 5'd10, 64'hCAFE_F00D_1234_5678, 7, 0);
    txn(0, 0, 0, 0, 64'h1234, 1, 5'd0, 64'h0, 0, 0);
    txn(0, 1, 0, 2, 64'h80, 1, 5'd11, 64'h0, 0, 0);
    txn(1, 0, 1, 3, 64'h8, 1, 5'd3, 64'h8765_4321_F0E1_D2C3, 2, 0);
    txn(1, 0, 1, 2, 64'h104, 1, 5'd12, 64'h8000_0001_7FFF_FFFF, 3, 1);
    txn(1, 1, 1, 1, 64'h2, 1, 5'd13, 64'h0000_0000_F00F_0000, 0, 0);
    txn(0, 1, 0, 3, 64'h3, 1, 5'd14, 64'h0, 0, 0);
    for (int i = 0; i < 150; i++) begin
      g_kind = $urandom_range(0, 7);
      g_sz = 2'($urandom_range(0, 3));
      g_res = {$urandom, $urandom};
      if ($urandom_range(0, 2) != 0) g_res[2:0] = g_res[2:0] & ~3'((8'd1 << g_sz) - 8'd1);
      g_wa = $urandom_range(0, 7) == 0 ? 5'd0 : 5'($urandom);
      g_data = {$urandom, $urandom};
      txn(g_kind >= 3, g_kind == 2 || g_kind == 7, 1'($urandom), g_sz, g_res,
          $urandom_range(0, 3) != 0, g_wa, g_data, $urandom_range(0, 7), $urandom_range(0, 3) == 0);
    end
    // back-to-back: a new instruction presented in the cycle right after the load completes
    expect_txn(1, 0, 1, 2, 64'h40, 1, 5'd3, 64'h0000_0000_8000_00AA, 0);
    expect_txn(0, 0, 0, 0, 64'hABCD, 1, 5'd4, 64'h0, 0);
    @(posedge clk); #1 present(1, 0, 1, 2, 64'h40, 1, 5'd3);
    @(posedge clk); #1 in_valid = 0; resp = 1; ram = 64'h0000_0000_8000_00AA;
    @(posedge clk); #1 resp = 0; present(0, 0, 0, 0, 64'hABCD, 1, 5'd4);
    @(posedge clk); #1 in_valid = 0;
    repeat (3) @(posedge clk);
    // reset while waiting abandons the load; the late response must be ignored
    sq0.push_back(1);
    sq1.push_back(1);
    #1 present(1, 0, 0, 2, 64'h100, 1, 5'd5);
    @(posedge clk); #1 in_valid = 0; rst = 1;
    @(posedge clk); #1 rst = 0; resp = 1; ram = 64'hFFFF_FFFF_FFFF_FFFF;
    @(posedge clk); #1 resp = 0;
    repeat (4) @(posedge clk);
    #1 done = 1;
    repeat (5) @(posedge clk);
    $display("FAIL summary_not_reached");
    $fatal(1);
  end
endmodule
